// File: rtl/interrupt_register.sv
// interrupt_register
//
// Four-bit interrupt/status register. Each of the four asynchronous switch
// inputs passes through its own SYNC_STAGES-deep synchronizer chain. While
// Write is high, the synchronized levels are loaded into a four-bit state
// register, and that register drives the outputs directly. While Write is low,
// the state register holds its value and the synchronizers keep sampling.
// Each bit is independent: a bit that was set is cleared again by a write of 0.
//
// Ports:
//   CLK        in   system clock; all state changes on its rising edge
//   CLR        in   synchronous active-low reset; clears synchronizers and state
//   Sw0..Sw3   in   switch levels, asynchronous to CLK
//   Write      in   capture enable, synchronous to CLK, active-high
//   Sw0_State..Sw3_State  out  registered switch state bits
//
// Parameter:
//   SYNC_STAGES  flip-flop stages per synchronizer; must be 2 or more (default 2)

module interrupt_register #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic Sw0,
    input  logic Sw1,
    input  logic Sw2,
    input  logic Sw3,
    input  logic Write,
    output logic Sw0_State,
    output logic Sw1_State,
    output logic Sw2_State,
    output logic Sw3_State
);

    // One synchronizer chain per switch. Bit 0 is the first stage.
    logic [SYNC_STAGES-1:0] chain_r [4];
    logic [3:0]             pins_s;
    logic [3:0]             sync_s;
    logic [3:0]             state_r;

    assign pins_s = {Sw3, Sw2, Sw1, Sw0};

    // Select the last stage of each chain as that switch's synchronized level.
    always_comb begin
        sync_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sync_s[i] = chain_r[i][SYNC_STAGES-1];
        end
    end

    // Synchronizer shift chains and state register. Reset takes priority over Write.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            for (int i = 0; i < 4; i++) begin
                chain_r[i] <= {SYNC_STAGES{1'b0}};
            end
            state_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                chain_r[i] <= {chain_r[i][SYNC_STAGES-2:0], pins_s[i]};
            end
            if (Write) begin
                // All four bits load together. There is no masking and no sticky OR.
                state_r <= sync_s;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign Sw0_State = state_r[0];
    assign Sw1_State = state_r[1];
    assign Sw2_State = state_r[2];
    assign Sw3_State = state_r[3];

endmodule

// File: tb/tb_interrupt_register.sv
// tb_interrupt_register
//
// Self-checking bench for interrupt_register. Each scenario task drives the
// pins, Write and CLR. Before each rising edge it pushes the expected state
// into a scoreboard queue. After the edge it pops that value and compares it
// with {Sw3_State, Sw2_State, Sw1_State, Sw0_State}.

module tb_interrupt_register;

    localparam int STAGES = 2;

    logic CLK;
    logic CLR;
    logic Sw0, Sw1, Sw2, Sw3;
    logic Write;
    logic Sw0_State, Sw1_State, Sw2_State, Sw3_State;

    int total;
    int bad;
    logic [3:0] exp_q [$];

    interrupt_register #(.SYNC_STAGES(STAGES)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .Sw0       (Sw0),
        .Sw1       (Sw1),
        .Sw2       (Sw2),
        .Sw3       (Sw3),
        .Write     (Write),
        .Sw0_State (Sw0_State),
        .Sw1_State (Sw1_State),
        .Sw2_State (Sw2_State),
        .Sw3_State (Sw3_State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [3:0] outs();
        return {Sw3_State, Sw2_State, Sw1_State, Sw0_State};
    endfunction

    task automatic set_pins(input logic [3:0] p);
        {Sw3, Sw2, Sw1, Sw0} = p;
    endtask

    // Push the expectation, advance one rising edge, then pop and compare.
    task automatic tick_expect(input string name, input logic [3:0] expv);
        logic [3:0] want;
        exp_q.push_back(expv);
        @(posedge CLK);
        #1;
        want = exp_q.pop_front();
        total++;
        if (outs() !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, outs(), want, $time);
        end
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        Write = 1'b1;
        set_pins(4'b1111);
        for (int i = 0; i < 5; i++) tick_expect("reset_hold", 4'b0000);
    endtask

    task automatic test_capture_all_ones();
        CLR = 1'b1;
        Write = 1'b1;
        set_pins(4'b0000);
        for (int i = 0; i < STAGES + 1; i++) tick_expect("capture_settle0", 4'b0000);
        set_pins(4'b1111);
        // The outputs must not show the new level before SYNC_STAGES+1 edges.
        for (int i = 0; i < STAGES; i++) tick_expect("capture_early", 4'b0000);
        tick_expect("capture_ones", 4'b1111);
    endtask

    task automatic test_pattern_clear();
        set_pins(4'b1010);
        for (int i = 0; i < STAGES; i++) tick_expect("pattern_early", 4'b1111);
        tick_expect("pattern_1010", 4'b1010);
        tick_expect("pattern_stable", 4'b1010);
    endtask

    task automatic test_hold();
        Write = 1'b0;
        set_pins(4'b0101);
        for (int i = 0; i < 10; i++) tick_expect("hold", 4'b1010);
        Write = 1'b1;
        tick_expect("hold_write_pulse", 4'b0101);
        Write = 1'b0;
        set_pins(4'b1111);
        tick_expect("hold_after_pulse", 4'b0101);
    endtask

    task automatic test_reset_priority();
        CLR = 1'b0;
        Write = 1'b1;
        set_pins(4'b1111);
        tick_expect("reset_priority", 4'b0000);
        CLR = 1'b1;
    endtask

    task automatic test_walk();
        logic [3:0] prev;
        logic [3:0] cur;
        prev = 4'b0000;
        Write = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cur = 4'b0001 << b;
            set_pins(cur);
            for (int i = 0; i < STAGES; i++) tick_expect("walk_early", prev);
            tick_expect("walk_bit", cur);
            prev = cur;
        end
    endtask

    task automatic test_back_to_back();
        // Load two patterns one after another. Then assert reset in the middle of pin activity.
        set_pins(4'b0110);
        for (int i = 0; i < STAGES; i++) tick_expect("b2b_early", 4'b1000);
        tick_expect("b2b_0110", 4'b0110);
        set_pins(4'b1001);
        for (int i = 0; i < STAGES; i++) tick_expect("b2b_early2", 4'b0110);
        tick_expect("b2b_1001", 4'b1001);
        CLR = 1'b0;
        set_pins(4'b1111);
        tick_expect("b2b_mid_reset", 4'b0000);
        CLR = 1'b1;
        // The synchronizers were cleared, so the first write after reset loads 0.
        tick_expect("b2b_post_reset", 4'b0000);
    endtask

    initial begin
        total = 0;
        bad = 0;
        CLR = 1'b0;
        Write = 1'b0;
        set_pins(4'b0000);
        #1;
        test_reset();
        test_capture_all_ones();
        test_pattern_clear();
        test_hold();
        test_reset_priority();
        test_walk();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
